// File: rtl/pulse_scheduler_pkg.sv
// Shared definitions for the pulse scheduler: FSM encoding, period decode and phase width.
package pulse_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int PHASE_W = 4;
  localparam int PERIOD_TAB [4] = '{2, 4, 8, 16};

  // Last phase value of a period: P-1 for period code sel.
  function automatic logic [PHASE_W-1:0] period_last(input logic [1:0] sel);
    return PHASE_W'(PERIOD_TAB[sel] - 1);
  endfunction

  // Pulse stays high while phase is below P/2.
  function automatic logic [PHASE_W-1:0] pulse_half(input logic [1:0] sel);
    return PHASE_W'(PERIOD_TAB[sel] / 2);
  endfunction

endpackage

// File: rtl/pulse_rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or above ptr, wrapping.
module pulse_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] g,
  output logic             any
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    g       = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        g       = w_idx;
      end
    end
    if (w_found) gnt[g] = 1'b1;
  end

  assign any = |req;

endmodule

// File: rtl/pulse_scheduler.sv
// Shares one programmable pulse generator among N_REQ requesters, round-robin, one burst at a time.
module pulse_scheduler
  import pulse_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       div_sel,
  input  logic [CNT_W*N_REQ-1:0]   burst_len,
  output logic [N_REQ-1:0]         grant,
  output logic                     pulse,
  output logic [N_REQ-1:0]         pulse_vec,
  output logic [N_REQ-1:0]         done,
  output logic                     busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_g;
  logic [N_REQ-1:0]   r_gnt;
  logic [1:0]         r_sel;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_npulse;
  logic [PHASE_W-1:0] r_phase;
  logic               r_zero;

  logic [N_REQ-1:0]   w_arb_gnt;
  logic [PTR_W-1:0]   w_arb_g;
  logic               w_arb_any;
  logic [1:0]         w_arb_sel;
  logic [CNT_W-1:0]   w_arb_len;
  logic               w_req_g;
  logic               w_period_end;
  logic               w_last;
  logic [PTR_W-1:0]   w_g_inc;

  pulse_rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_arb_gnt),
    .g   (w_arb_g),
    .any (w_arb_any)
  );

  assign w_arb_sel    = div_sel[2*int'(w_arb_g) +: 2];
  assign w_arb_len    = burst_len[CNT_W*int'(w_arb_g) +: CNT_W];
  assign w_req_g      = req[r_g];
  assign w_period_end = (r_phase == period_last(r_sel));
  // Terminal compare at len-1 keeps npulse from ever wrapping.
  assign w_last       = (r_npulse == r_len - CNT_W'(1));
  assign w_g_inc      = (r_g == PTR_W'(N_REQ - 1)) ? '0 : r_g + PTR_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_arb_any) w_state_nxt = (w_arb_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (!w_req_g)                    w_state_nxt = ST_IDLE;
        else if (w_period_end && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: if (!r_zero) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_g      <= '0;
      r_gnt    <= '0;
      r_sel    <= '0;
      r_len    <= '0;
      r_npulse <= '0;
      r_phase  <= '0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_any) begin
            r_g      <= w_arb_g;
            r_gnt    <= w_arb_gnt;
            r_sel    <= w_arb_sel;
            r_len    <= w_arb_len;
            r_npulse <= '0;
            r_phase  <= '0;
            r_zero   <= (w_arb_len == '0);
          end
        end
        ST_RUN: begin
          if (!w_req_g) begin
            r_ptr <= w_g_inc;
          end else if (w_period_end) begin
            r_phase  <= '0;
            r_npulse <= r_npulse + CNT_W'(1);
          end else begin
            r_phase  <= r_phase + PHASE_W'(1);
          end
        end
        ST_DONE: begin
          // A zero-length grant spends its first DONE cycle showing grant, the second showing done.
          r_zero <= 1'b0;
          if (!r_zero) r_ptr <= w_g_inc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    grant     = '0;
    pulse     = 1'b0;
    pulse_vec = '0;
    done      = '0;
    busy      = 1'b0;
    case (r_state)
      ST_RUN: begin
        busy  = 1'b1;
        grant = r_gnt;
        pulse = (r_phase < pulse_half(r_sel));
        if (pulse) pulse_vec = r_gnt;
      end
      ST_DONE: begin
        busy = 1'b1;
        if (r_zero) grant = r_gnt;
        else        done  = r_gnt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Bench for pulse_scheduler: directed scenarios plus random traffic against a burst-level model.
module tb_pulse_scheduler;

  localparam int N  = 4;
  localparam int CW = 4;

  logic          clock;
  logic          reset;
  logic [N-1:0]  req;
  logic [2*N-1:0] div_sel;
  logic [CW*N-1:0] burst_len;
  logic [N-1:0]  grant;
  logic          pulse;
  logic [N-1:0]  pulse_vec;
  logic [N-1:0]  done;
  logic          busy;

  int n_vec;
  int n_err;

  // Model: mode 0 idle, 1 bursting, 2 completion cycle, 3 zero-length grant cycle.
  int m_mode, m_g, m_ptr, m_P, m_L, m_cyc;

  pulse_scheduler #(.N_REQ(N), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .div_sel   (div_sel),
    .burst_len (burst_len),
    .grant     (grant),
    .pulse     (pulse),
    .pulse_vec (pulse_vec),
    .done      (done),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int div_f(input int i);
    return (int'(div_sel) >> (2 * i)) & 3;
  endfunction

  function automatic int len_f(input int i);
    return (int'(burst_len) >> (CW * i)) & 15;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic set_div(input int i, input int v);
    div_sel[2*i +: 2] = 2'(v);
  endtask

  task automatic set_len(input int i, input int v);
    burst_len[CW*i +: CW] = 4'(v);
  endtask

  task automatic model_reset();
    m_mode = 0; m_g = 0; m_ptr = 0; m_P = 2; m_L = 0; m_cyc = 0;
  endtask

  task automatic model_edge();
    int idx;
    int found;
    case (m_mode)
      0: begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (found == 0 && ((int'(req) >> idx) & 1) == 1) begin
            found = 1;
            m_g   = idx;
          end
        end
        if (found == 1) begin
          m_P   = 2 << div_f(m_g);
          m_L   = len_f(m_g);
          m_cyc = 0;
          m_mode = (m_L == 0) ? 3 : 1;
        end
      end
      1: begin
        if (((int'(req) >> m_g) & 1) == 0) begin
          m_mode = 0;
          m_ptr  = (m_g + 1) % N;
        end else begin
          m_cyc++;
          if (m_cyc == m_L * m_P) m_mode = 2;
        end
      end
      2: begin
        m_mode = 0;
        m_ptr  = (m_g + 1) % N;
      end
      default: m_mode = 2;
    endcase
  endtask

  task automatic check_outputs();
    int e_grant, e_pulse, e_pv, e_done, e_busy;
    e_grant = (m_mode == 1 || m_mode == 3) ? (1 << m_g) : 0;
    e_pulse = (m_mode == 1 && (m_cyc % m_P) < m_P / 2) ? 1 : 0;
    e_pv    = (e_pulse == 1) ? e_grant : 0;
    e_done  = (m_mode == 2) ? (1 << m_g) : 0;
    e_busy  = (m_mode != 0) ? 1 : 0;
    chk("grant", 32'(grant), e_grant);
    chk("pulse", 32'(pulse), e_pulse);
    chk("pulse_vec", 32'(pulse_vec), e_pv);
    chk("done", 32'(done), e_done);
    chk("busy", 32'(busy), e_busy);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    check_outputs();
  endtask

  initial begin
    int gcnt, pat, dcnt, prev, gi;
    int order[$];
    int exp_rr[5];
    exp_rr = '{0, 1, 3, 0, 1};
    n_vec = 0; n_err = 0;
    req = '0; div_sel = '0; burst_len = '0;
    reset = 1'b1;
    model_reset();
    #2;
    check_outputs();
    do_reset();

    // Single short burst: P=4, three pulses.
    set_div(0, 1); set_len(0, 3); req = 4'b0001;
    gcnt = 0; pat = 0; dcnt = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (grant[0]) begin gcnt++; pat = (pat << 1) | int'(pulse); end
      if (done[0]) begin dcnt++; req = '0; end
    end
    chk("s1_grant_cycles", gcnt, 12);
    chk("s1_pulse_pattern", pat, 32'hCCC);
    chk("s1_done_count", dcnt, 1);
    chk("s1_busy_after", 32'(busy), 0);

    // Round robin with req 1011, length 1, P=2.
    do_reset();
    div_sel = '0; burst_len = 16'h1111; req = 4'b1011;
    prev = 0;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      step();
      if (grant != '0 && prev == 0) order.push_back(oh_idx(grant));
      if (done != '0 && order.size() > 0) chk("s2_done_bit", 32'(done), 1 << order[order.size()-1]);
      prev = int'(grant);
    end
    chk("s2_grant_count", order.size(), 5);
    for (int i = 0; i < order.size() && i < 5; i++) chk("s2_grant_order", order[i], exp_rr[i]);
    req = '0;
    repeat (6) step();

    // Zero-length burst on requester 2.
    do_reset();
    burst_len = '0; req = 4'b0100;
    step();
    chk("s3_grant", 32'(grant), 32'h4);
    chk("s3_no_pulse", 32'(pulse), 0);
    step();
    chk("s3_grant_off", 32'(grant), 0);
    chk("s3_done", 32'(done), 32'h4);
    req = '0;
    repeat (3) step();

    // Abort: P=16, length 5, drop req[1] on cycle 20.
    do_reset();
    set_div(1, 3); set_len(1, 5); req = 4'b0010;
    repeat (20) step();
    req = '0;
    step();
    chk("s4_idle", 32'(busy), 0);
    chk("s4_no_done", 32'(done), 0);
    set_len(0, 1); set_len(2, 1); set_div(0, 0); set_div(2, 0);
    req = 4'b0101;
    step();
    chk("s4_ptr_next", 32'(grant), 32'h4);
    req = '0;
    repeat (4) step();

    // Asynchronous reset in the middle of a pulse.
    do_reset();
    set_div(1, 2); set_len(1, 3); req = 4'b0110;
    step();
    step();
    chk("s5_pulse_pre", 32'(pulse), 1);
    #2 reset = 1'b1;
    #1;
    chk("s5_pulse_rst", 32'(pulse), 0);
    chk("s5_grant_rst", 32'(grant), 0);
    chk("s5_busy_rst", 32'(busy), 0);
    model_reset();
    @(posedge clock);
    #3 reset = 1'b0;
    step();
    chk("s5_first_grant", 32'(grant), 32'h2);
    req = '0;
    repeat (3) step();

    // div_sel change after grant must not alter the burst.
    do_reset();
    div_sel = '0; burst_len = '0; set_len(0, 4); req = 4'b0001;
    step();
    set_div(0, 3);
    gcnt = 0; pat = 0;
    for (int c = 0; c < 14; c++) begin
      if (grant[0]) begin gcnt++; pat = (pat << 1) | int'(pulse); end
      if (done[0]) req = '0;
      step();
    end
    chk("s6_run_cycles", gcnt, 8);
    chk("s6_pulse_pattern", pat, 32'hAA);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        div_sel   = 8'($urandom);
        burst_len = 16'($urandom) & 16'h3333;
      end
      for (int i = 0; i < N; i++) if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
